// File: rtl/pdm_sampler_multi.sv
// Multi-line stereo PDM front end: internal PDM clock generator, programmable
// per-half sample point, per-channel bit packing and a valid/ready frame stream.
module pdm_sampler_multi #(
  parameter int NUM_LINES = 1,
  parameter int PACK_W    = 8,
  parameter int DIV_W     = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            en_i,
  input  logic [DIV_W-1:0]                clk_div_i,
  input  logic [DIV_W-1:0]                sample_dly_i,
  input  logic [NUM_LINES-1:0]            data_i,
  output logic                            pdm_clk_o,
  output logic [2*NUM_LINES*PACK_W-1:0]   data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            overflow_o
);

  localparam int NCH = 2 * NUM_LINES;
  localparam int FW  = NCH * PACK_W;
  localparam int PW  = (PACK_W > 1) ? $clog2(PACK_W) : 1;

  // state   | meaning
  // HALF_LO | pdm_clk_o low, captures feed right channels (2l+1)
  // HALF_HI | pdm_clk_o high, captures feed left channels (2l)
  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_t;

  half_t             half_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  dly_q;
  logic              primed_q;
  logic [PW-1:0]     pair_q;
  logic [FW-1:0]     sr_q;
  logic [FW-1:0]     data_q;
  logic              valid_q;
  logic              overflow_q;

  logic [DIV_W-1:0]  div_in;
  logic [DIV_W-1:0]  dly_in;
  logic [DIV_W-1:0]  div_use;
  logic [DIV_W-1:0]  dly_use;
  logic              half_end;
  logic              cap;
  logic              cap_l;
  logic              cap_r;
  logic              frame_done;
  logic [PW-1:0]     pair_d;
  logic [FW-1:0]     sr_d;

  // Half-period settings are taken live on the first cycle of a half (cnt==0)
  // and held from the latch for the rest of it, so a half is never shortened.
  always_comb begin
    div_in  = (clk_div_i < DIV_W'(2)) ? DIV_W'(2) : clk_div_i;
    dly_in  = (sample_dly_i > (div_in - DIV_W'(1))) ? (div_in - DIV_W'(1)) : sample_dly_i;
    div_use = (cnt_q == '0) ? div_in : div_q;
    dly_use = (cnt_q == '0) ? dly_in : dly_q;

    half_end   = (cnt_q == (div_use - DIV_W'(1)));
    cap        = (cnt_q == dly_use);
    cap_l      = cap && (half_q == HALF_HI);
    cap_r      = cap && (half_q == HALF_LO) && primed_q;
    frame_done = cap_r && (pair_q == PW'(PACK_W - 1));

    pair_d = pair_q;
    if (cap_r) begin
      pair_d = frame_done ? '0 : pair_q + PW'(1);
    end

    sr_d = sr_q;
    for (int l = 0; l < NUM_LINES; l++) begin
      if (cap_l) begin
        sr_d[(2*l)*PACK_W +: PACK_W] = {sr_q[(2*l)*PACK_W +: PACK_W-1], data_i[l]};
      end
      if (cap_r) begin
        sr_d[(2*l+1)*PACK_W +: PACK_W] = {sr_q[(2*l+1)*PACK_W +: PACK_W-1], data_i[l]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !en_i) begin
      half_q     <= HALF_LO;
      cnt_q      <= '0;
      div_q      <= '0;
      dly_q      <= '0;
      primed_q   <= 1'b0;
      pair_q     <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (cnt_q == '0) begin
        div_q <= div_in;
        dly_q <= dly_in;
      end
      if (half_end) begin
        cnt_q  <= '0;
        half_q <= (half_q == HALF_HI) ? HALF_LO : HALF_HI;
      end else begin
        cnt_q  <= cnt_q + DIV_W'(1);
      end

      primed_q <= primed_q | cap_l;
      pair_q   <= pair_d;
      sr_q     <= sr_d;

      // A completed frame may replace the one being accepted this cycle.
      if (frame_done) begin
        if (!valid_q || ready_i) begin
          data_q  <= sr_d;
          valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pdm_clk_o  = (half_q == HALF_HI);
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pdm_sampler_multi.sv
// Randomized bench for pdm_sampler_multi: two instances (1 line x 8 bits and
// 2 lines x 4 bits) checked every cycle against a capture-schedule reference.
module tb_pdm_sampler_multi;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        ready = 1'b0;
  logic [3:0]  cdiv  = 4'd2;
  logic [3:0]  sdly  = 4'd0;
  logic [1:0]  din   = 2'b00;

  logic        pdm1, v1, ovf1, pdm2, v2, ovf2;
  logic [15:0] d1, d2;

  pdm_sampler_multi #(.NUM_LINES(1), .PACK_W(8), .DIV_W(4)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clk_div_i(cdiv), .sample_dly_i(sdly),
    .data_i(din[0:0]), .pdm_clk_o(pdm1), .data_o(d1), .valid_o(v1), .ready_i(ready),
    .overflow_o(ovf1)
  );

  pdm_sampler_multi #(.NUM_LINES(2), .PACK_W(4), .DIV_W(4)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clk_div_i(cdiv), .sample_dly_i(sdly),
    .data_i(din), .pdm_clk_o(pdm2), .data_o(d2), .valid_o(v2), .ready_i(ready),
    .overflow_o(ovf2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference state: k = cycles since enable, capture history indexed by k.
  int          k = 0;
  int          dv = 2, dl = 0, mode = 0, rmode = 0;
  logic [1:0]  hist [0:1023];
  bit          mv [2];
  bit          mo [2];
  logic [15:0] md [2];

  function automatic logic [1:0] stim(int m, int kk);
    int h, tog;
    h = kk / dv;
    case (m)
      1: return (h % 2 == 1) ? 2'b11 : 2'b00;
      2: begin
        tog = (kk >= 2) ? (((kk - 2) / dv + 1) % 2) : 0;
        return (tog == 1) ? 2'b11 : 2'b00;
      end
      3: return (h % 2 == 1 && ((h - 1) / 2) % 2 == 0) ? 2'b11 : 2'b00;
      4: return 2'b10;
      default: return 2'($urandom);
    endcase
  endfunction

  // Frame f ends on the right capture of half 2*(f+1)*P; left halves are odd.
  function automatic bit is_done(int inst, int kk);
    int p, hr;
    p = (inst == 1) ? 4 : 8;
    if (kk < dl) return 1'b0;
    if ((kk - dl) % dv != 0) return 1'b0;
    hr = (kk - dl) / dv;
    return (hr > 0) && (hr % (2 * p) == 0);
  endfunction

  function automatic logic [15:0] frame(int inst, int kk);
    int p, nl, first, kl, kr;
    logic [15:0] fr;
    p  = (inst == 1) ? 4 : 8;
    nl = (inst == 1) ? 2 : 1;
    first = (kk - dl) / dv - 2 * p + 1;
    fr = '0;
    for (int j = 0; j < p; j++) begin
      kl = (first + 2 * j) * dv + dl;
      kr = kl + dv;
      for (int l = 0; l < nl; l++) begin
        fr[(2*l)*p + p-1-j]   = hist[kl][l];
        fr[(2*l+1)*p + p-1-j] = hist[kr][l];
      end
    end
    return fr;
  endfunction

  task automatic cycle(input bit en_v, input bit rst_v);
    @(posedge clk); #1;
    chk("pdm_clk1", {15'd0, pdm1}, {15'd0, 1'((k / dv) % 2)});
    chk("pdm_clk2", {15'd0, pdm2}, {15'd0, 1'((k / dv) % 2)});
    chk("valid1", {15'd0, v1}, {15'd0, mv[0]});
    chk("valid2", {15'd0, v2}, {15'd0, mv[1]});
    chk("overflow1", {15'd0, ovf1}, {15'd0, mo[0]});
    chk("overflow2", {15'd0, ovf2}, {15'd0, mo[1]});
    chk("data1", d1, md[0]);
    chk("data2", d2, md[1]);
    if (mv[0] && mode == 1) chk("left_ones", d1, 16'h00FF);
    if (mv[0] && mode == 3) chk("left_alt", d1, 16'h00AA);
    if (mv[1] && mode == 4) chk("multi_line", d2, 16'hFF00);

    en    = en_v;
    rst_n = rst_v;
    din   = stim(mode, k);
    case (rmode)
      0: ready = ($urandom_range(0, 9) != 0);
      1: ready = (k >= 300);
      default: ready = 1'($urandom);
    endcase
    hist[k] = din;

    if (!en_v || !rst_v) begin
      k = 0;
      for (int i = 0; i < 2; i++) begin
        mv[i] = 1'b0; mo[i] = 1'b0; md[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (is_done(i, k)) begin
          if (!mv[i] || ready) begin
            mv[i] = 1'b1;
            md[i] = frame(i, k);
          end else begin
            mo[i] = 1'b1;
          end
        end else if (mv[i] && ready) begin
          mv[i] = 1'b0;
        end
      end
      k++;
    end
  endtask

  task automatic run(input int cd, input int sd, input int m, input int rm, input int len);
    cdiv  = 4'(cd);
    sdly  = 4'(sd);
    dv    = (cd < 2) ? 2 : cd;
    dl    = (sd > dv - 1) ? dv - 1 : sd;
    mode  = m;
    rmode = rm;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < len; i++) cycle(1'b1, 1'b1);
    if ($urandom_range(0, 1) == 1) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) cycle(1'b1, 1'b0);
    end else begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) cycle(1'b0, 1'b1);
    end
  endtask

  int t_div  [9] = '{3, 0, 1, 2, 2, 4, 4, 4, 2};
  int t_dly  [9] = '{0, 0, 0, 1, 1, 1, 3, 9, 1};
  int t_mode [9] = '{0, 0, 0, 1, 3, 2, 2, 2, 4};
  int t_rm   [9] = '{0, 0, 2, 0, 0, 2, 0, 0, 1};

  initial begin
    for (int i = 0; i < 1024; i++) hist[i] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; mo[i] = 1'b0; md[i] = '0;
    end
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);

    for (int r = 0; r < 9; r++) run(t_div[r], t_dly[r], t_mode[r], t_rm[r], (r == 8) ? 400 : 300);
    for (int r = 0; r < 12; r++) begin
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 2)), int'($urandom_range(100, 500)));
    end

    // Divider change mid-half: first half keeps 4 cycles, following halves use 2.
    @(posedge clk); #1;
    rst_n = 1'b0; en = 1'b1; cdiv = 4'd4; sdly = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int kk = 0; kk < 10; kk++) begin
      chk("div_change_pdm", {15'd0, pdm1},
          (kk < 4) ? 16'd0 : {15'd0, 1'(((kk - 4) / 2) % 2 == 0)});
      if (kk == 1) cdiv = 4'd2;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
